// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: steps one full-adder cell over WIDTH cycles,
// LSB first. The operands are latched on an accepted start, the carry is
// kept in a flip-flop, and the sum is assembled in a right-shifting register.
// The result is published with a single-cycle done pulse.
// WIDTH is legal from 1 to 32.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             overflow
);

  // One extra counter bit, so the count never wraps inside a legal run.
  localparam int               CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_shift;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_next;
  logic             accept;
  logic             last_bit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state is written with <= so every flop samples
      // its inputs from before the edge, whatever order the blocks run in.
      state <= state_next;
    end
  end

  // Next-state decode and the status outputs derived from the state.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The full-adder cell and the sum register with the new bit shifted in at the top.
  always_comb begin
    s         = sa[0] ^ sb[0] ^ c;
    c_next    = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    sum_shift = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
  end

  // Operand shifters, carry flop, bit counter and the registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are few and small, so all of them are
      // cleared. An aborted run then leaves nothing stale behind.
      sa       <= '0;
      sb       <= '0;
      sum_sr   <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      F        <= '0;
      Cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        sa     <= A;
        sb     <= B;
        c      <= Cin;
        cnt    <= '0;
        sum_sr <= '0;
      end else if (state == RUN) begin
        sa     <= sa >> 1;
        sb     <= sb >> 1;
        sum_sr <= sum_shift;
        c      <= c_next;
        cnt    <= cnt + 1'b1;
      end
      // On the final bit, c is the carry into the MSB and c_next is the carry out of it.
      if (last_bit) begin
        F        <= sum_shift;
        Cout     <= c_next;
        overflow <= c ^ c_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl. It runs a WIDTH=8 and a WIDTH=1 instance
// side by side on one clock and reset. Expected results are queued when an
// operation is started and checked when that instance pulses done.
module tb_serial_adder_ctrl;

  typedef struct packed {
    logic [7:0] f;
    logic       cout;
    logic       ovf;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8     = '0;
  logic [7:0] b8     = '0;
  logic       cin8   = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] f8;
  logic       cout8;
  logic       ovf8;

  logic       start1 = 1'b0;
  logic [0:0] a1     = '0;
  logic [0:0] b1     = '0;
  logic       cin1   = 1'b0;
  logic       busy1;
  logic       done1;
  logic [0:0] f1;
  logic       cout1;
  logic       ovf1;

  res_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .F(f8), .Cout(cout8), .overflow(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .F(f1), .Cout(cout1), .overflow(ovf1)
  );

  // Present operands and start for one edge, then drop start and scramble
  // the operand inputs so a design that re-reads them would be caught.
  task automatic start_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic cin);
    @(negedge clk);
    if (sel) begin
      a1 = a[0:0]; b1 = b[0:0]; cin1 = cin; start1 = 1'b1;
    end else begin
      a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    cin8   = ~cin8;
    a1     = ~a1;
    b1     = ~b1;
    cin1   = ~cin1;
  endtask

  // Bounded wait for done. cyc = cycle index of done, counted from 1 for the
  // cycle after the accepting edge, or -1 on timeout. busy_cyc counts the busy cycles.
  // f_changed is set if F moved before done.
  task automatic wait_done(input bit sel, input int budget, output int cyc,
                           output int busy_cyc, output bit f_changed);
    logic [7:0] f0;
    f0        = sel ? {7'b0, f1} : f8;
    cyc       = -1;
    busy_cyc  = 0;
    f_changed = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (sel ? busy1 : busy8) busy_cyc++;
      if (sel ? done1 : done8) begin
        cyc = n;
        return;
      end
      if ((sel ? {7'b0, f1} : f8) !== f0) f_changed = 1'b1;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy8, done8, f8, cout8, ovf8} !== 12'h000) begin
      failures++;
      $display("FAIL reset_w8 got busy=%b done=%b f=%h cout=%b ovf=%b exp all zero",
               busy8, done8, f8, cout8, ovf8);
    end
    checks++;
    if ({busy1, done1, f1, cout1, ovf1} !== 5'b0) begin
      failures++;
      $display("FAIL reset_w1 got busy=%b done=%b f=%b cout=%b ovf=%b exp all zero",
               busy1, done1, f1, cout1, ovf1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One WIDTH=8 addition from idle: latency, busy span, F hold and result.
  task automatic test_single(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic cin, input res_t exp);
    int   cyc;
    int   bcyc;
    bit   fch;
    res_t e;
    res_t g;
    sb_q.push_back(exp);
    start_op(1'b0, a, b, cin);
    wait_done(1'b0, 30, cyc, bcyc, fch);
    checks++;
    if (cyc !== 9) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=9", name, cyc);
    end
    checks++;
    if (bcyc !== 9) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d exp=9", name, bcyc);
    end
    checks++;
    if (fch !== 1'b0) begin
      failures++;
      $display("FAIL %s_f_hold got=changed exp=held", name);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = '{f: f8, cout: cout8, ovf: ovf8};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s_result got f=%h cout=%b ovf=%b exp f=%h cout=%b ovf=%b",
                 name, g.f, g.cout, g.ovf, e.f, e.cout, e.ovf);
      end
    end
    @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      failures++;
      $display("FAIL %s_back_to_idle got busy=%b done=%b exp 0 0", name, busy8, done8);
    end
  endtask

  task automatic test_width1;
    logic [1:0] tbl [8];
    logic [2:0] vv;
    int         cyc;
    int         bcyc;
    bit         fch;
    res_t       e;
    res_t       g;
    tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      sb_q.push_back('{f: {7'b0, tbl[v][0]}, cout: tbl[v][1], ovf: vv[0] ^ tbl[v][1]});
      start_op(1'b1, {7'b0, vv[2]}, {7'b0, vv[1]}, vv[0]);
      wait_done(1'b1, 10, cyc, bcyc, fch);
      checks++;
      if (cyc !== 2 || bcyc !== 2) begin
        failures++;
        $display("FAIL w1_timing_%0d got done_cycle=%0d busy_cycles=%0d exp 2 2", v, cyc, bcyc);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = '{f: {7'b0, f1}, cout: cout1, ovf: ovf1};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL w1_result_%0d got f=%h cout=%b ovf=%b exp f=%h cout=%b ovf=%b",
                   v, g.f, g.cout, g.ovf, e.f, e.cout, e.ovf);
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    int   dones;
    int   first;
    res_t e;
    res_t g;
    dones = 0;
    first = -1;
    sb_q.push_back('{f: 8'h46, cout: 1'b0, ovf: 1'b0});
    start_op(1'b0, 8'h12, 8'h34, 1'b0);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 3) begin
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      end
      if (n == 4) start8 = 1'b0;
      if (done8 === 1'b1) begin
        dones++;
        if (first < 0) first = n;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          g = '{f: f8, cout: cout8, ovf: ovf8};
          checks++;
          if (g !== e) begin
            failures++;
            $display("FAIL ignore_result got f=%h cout=%b ovf=%b exp f=%h cout=%b ovf=%b",
                     g.f, g.cout, g.ovf, e.f, e.cout, e.ovf);
          end
        end
      end
    end
    checks++;
    if (dones !== 1 || first !== 9) begin
      failures++;
      $display("FAIL ignore_done_count got dones=%0d first=%0d exp 1 at 9", dones, first);
    end
  endtask

  task automatic test_async_reset;
    int dones;
    dones = 0;
    start_op(1'b0, 8'hA5, 8'h0F, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, f8, cout8, ovf8} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset got busy=%b done=%b f=%h cout=%b ovf=%b exp all zero",
               busy8, done8, f8, cout8, ovf8);
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL async_reset_quiet got active_cycles=%0d exp 0", dones);
    end
    rst = 1'b0;
    test_single("after_reset", 8'h80, 8'h80, 1'b0, '{f: 8'h00, cout: 1'b1, ovf: 1'b1});
  endtask

  task automatic test_back_to_back;
    int   dones;
    res_t e;
    res_t g;
    dones = 0;
    for (int i = 0; i < 3; i++) sb_q.push_back('{f: 8'h80, cout: 1'b0, ovf: 1'b1});
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      checks++;
      if (done8 !== 1'((n % 10) == 9)) begin
        failures++;
        $display("FAIL b2b_done_c%0d got=%b exp=%b", n, done8, (n % 10) == 9);
      end
      if (done8 === 1'b1 && sb_q.size() > 0) begin
        dones++;
        e = sb_q.pop_front();
        g = '{f: f8, cout: cout8, ovf: ovf8};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL b2b_result_%0d got f=%h cout=%b ovf=%b exp f=%h cout=%b ovf=%b",
                   dones, g.f, g.cout, g.ovf, e.f, e.cout, e.ovf);
        end
      end
    end
    start8 = 1'b0;
    checks++;
    if (dones !== 3) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=3", dones);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_width1();
    test_single("add_5a_3c", 8'h5A, 8'h3C, 1'b0, '{f: 8'h96, cout: 1'b0, ovf: 1'b1});
    test_single("add_ff_01", 8'hFF, 8'h01, 1'b0, '{f: 8'h00, cout: 1'b1, ovf: 1'b0});
    test_single("carry_in",  8'h00, 8'h00, 1'b1, '{f: 8'h01, cout: 1'b0, ovf: 1'b0});
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller that sequences a single 1-bit full-adder cell (F = A^B^Cin, Cout = majority) over WIDTH clock cycles, LSB first.
- It latches the operands on a start request, steps the carry through an internal carry flip-flop, and assembles the sum in a shift register.
- It presents the result with a one-cycle done pulse.
- It sits between the lab's operand registers or switches and the result display. It is the sequencing layer for the combinational full adder used in the arithmetic experiments.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; sampled on the accepting edge only.
- B  input  WIDTH  operand B; sampled on the accepting edge only.
- Cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; result valid.
- F  output  WIDTH  sum; registered, updated only on completion.
- Cout  output  1  carry out of bit WIDTH-1; registered.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB); registered.

Behaviour:
- Reset (async, any state): state=IDLE. busy=0, done=0, F=0, Cout=0, overflow=0. Shift registers, carry flip-flop and bit counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: load sa<=A, sb<=B, c<=Cin, cnt<=0, sum_sr<=0; go to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - s = sa[0]^sb[0]^c; c_next = (sa[0]&sb[0]) | (c&(sa[0]^sb[0])).
  - sa and sb shift right by 1.
  - sum_sr shifts right with s entering at bit WIDTH-1.
  - c <= c_next; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (the final bit):
    - F <= {s, sum_sr[WIDTH-1:1]}.
    - Cout <= c_next.
    - overflow <= c XOR c_next, where c is the carry into the MSB.
    - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k. RUN covers edges k+1..k+WIDTH. done is high during the cycle following edge k+WIDTH. Earliest next acceptance is edge k+WIDTH+2.
- busy=1 from the cycle after the accepting edge through the done cycle inclusive.
- F, Cout and overflow hold their last completed values during RUN and IDLE. Their only changes are at completion and on reset.
- start while busy (RUN or DONE) is ignored; no queuing.
- Holding start high continuously yields back-to-back additions every WIDTH+2 cycles.
- A, B and Cin changing after acceptance have no effect on the in-flight addition.
- Reset asserted mid-RUN aborts the operation immediately. Outputs go to 0 and no done pulse is produced. The first start after reset release is accepted normally.
- WIDTH=1: RUN lasts one edge; overflow = Cin XOR Cout.
- cnt width is clog2(WIDTH)+1 bits; no wrap occurs within a legal run.

Test Plan:
- WIDTH=1, all 8 combinations of A, B, Cin applied sequentially (000..111) -> {Cout,F} = 00, 01, 01, 10, 01, 10, 10, 11. done pulses exactly 2 cycles after each accepting edge.
- WIDTH=8, A=8'h5A, B=8'h3C, Cin=0 -> F=8'h96, Cout=0, overflow=1. busy high for 9 cycles. done high for exactly 1 cycle, 9 cycles after the accepting edge.
- WIDTH=8:
  - A=8'hFF, B=8'h01, Cin=0 -> F=8'h00, Cout=1, overflow=0.
  - Then A=8'h00, B=8'h00, Cin=1 -> F=8'h01, Cout=0, overflow=0.
  - F holds 8'h00 throughout the second RUN.
- WIDTH=8, start pulsed again 3 cycles into RUN with A=8'h01, B=8'h01 -> ignored. First result (8'h12+8'h34=8'h46) completes unchanged. Only one done pulse.
- WIDTH=8, rst asserted asynchronously mid-cycle at RUN bit 4 -> busy, done, F, Cout and overflow go to 0 immediately without waiting for a clock edge. No done pulse. A subsequent start with 8'h80+8'h80 -> F=8'h00, Cout=1, overflow=1.
- WIDTH=8, start held high for 30 cycles with constant A=8'h7F, B=8'h01 -> done pulses every 10 cycles. Each result is F=8'h80, Cout=0, overflow=1.
